// File: rtl/gecko_pkg.sv
// Shared types and the load alignment helper for the gecko load writeback path.
package gecko_pkg;

  // RV32I load funct3 encodings; 3, 6 and 7 are not loads and produce zero.
  typedef enum logic [2:0] {
    LS_LB  = 3'd0,
    LS_LH  = 3'd1,
    LS_LW  = 3'd2,
    LS_LBU = 3'd4,
    LS_LHU = 3'd5
  } gecko_ls_funct3_e;

  // Widest scoreboard tag the command record can carry.
  localparam int unsigned GECKO_REG_STATUS_W_MAX = 8;

  typedef struct packed {
    logic [4:0]                        addr;
    logic [2:0]                        op;
    logic [1:0]                        offset;
    logic [GECKO_REG_STATUS_W_MAX-1:0] reg_status;
    logic                              jump_flag;
  } gecko_load_wb_cmd_t;

  typedef struct packed {
    logic [31:0] value;
    logic        misaligned;
  } gecko_load_result_t;

  function automatic gecko_load_result_t gecko_get_load_result(
    input logic [31:0] data,
    input logic [1:0]  offset,
    input logic [2:0]  op
  );
    gecko_load_result_t res;
    logic [31:0]        shifted;
    logic [7:0]         byte_val;
    logic [15:0]        half_val;
    shifted  = data >> {offset, 3'b000};
    byte_val = shifted[7:0];
    half_val = offset[1] ? data[31:16] : data[15:0];
    res      = '0;
    case (op)
      LS_LB:  res.value = {{24{byte_val[7]}}, byte_val};
      LS_LBU: res.value = {24'd0, byte_val};
      LS_LH: begin
        res.value      = {{16{half_val[15]}}, half_val};
        res.misaligned = offset[0];
      end
      LS_LHU: begin
        res.value      = {16'd0, half_val};
        res.misaligned = offset[0];
      end
      LS_LW: begin
        res.value      = data;
        res.misaligned = (offset != 2'd0);
      end
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gecko_load_queue.sv
// Circular FIFO of pending load commands with a separately tracked occupancy count.
module gecko_load_queue
  import gecko_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  gecko_load_wb_cmd_t           push_data,
  input  logic                         pop,
  output gecko_load_wb_cmd_t           head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  gecko_load_wb_cmd_t mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap without explicit compare.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gecko_load_writeback.sv
// Pairs queued load commands with memory read responses and emits aligned writebacks.
// Optional GECKO_LOAD_MISALIGN_CHECK_EN adds a sticky misaligned flag and zeroes misaligned results.
module gecko_load_writeback
  import gecko_pkg::*;
#(
  parameter int unsigned CMD_DEPTH        = 4,
  parameter int unsigned REG_STATUS_WIDTH = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [4:0]                        cmd_addr,
  input  logic [2:0]                        cmd_op,
  input  logic [1:0]                        cmd_offset,
  input  logic [REG_STATUS_WIDTH-1:0]       cmd_reg_status,
  input  logic                              cmd_jump_flag,
  input  logic                              rsp_valid,
  output logic                              rsp_ready,
  input  logic [31:0]                       rsp_data,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [31:0]                       res_value,
  output logic [4:0]                        res_addr,
  output logic [REG_STATUS_WIDTH-1:0]       res_reg_status,
  output logic                              res_jump_flag,
  output logic                              res_speculative,
`ifdef GECKO_LOAD_MISALIGN_CHECK_EN
  output logic                              misaligned,
`endif
  output logic [$clog2(CMD_DEPTH+1)-1:0]    pending
);

  gecko_load_wb_cmd_t cmd_in;
  gecko_load_wb_cmd_t head;
  gecko_load_result_t load_res;
  logic [31:0]        load_value;
  logic               full;
  logic               empty;
  logic               init_done;
  logic               push;
  logic               can_out;
  logic               fire;
  logic               unused_rs_hi;

  always_comb begin
    cmd_in            = '0;
    cmd_in.addr       = cmd_addr;
    cmd_in.op         = cmd_op;
    cmd_in.offset     = cmd_offset;
    cmd_in.reg_status = GECKO_REG_STATUS_W_MAX'(cmd_reg_status);
    cmd_in.jump_flag  = cmd_jump_flag;
  end

  gecko_load_queue #(
    .DEPTH (CMD_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (cmd_in),
    .pop       (fire),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (pending)
  );

  // Holds cmd_ready low until the first clock after reset is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) init_done <= 1'b0;
    else      init_done <= 1'b1;
  end

  assign cmd_ready = init_done && !full;
  assign push      = cmd_valid && cmd_ready;
  assign can_out   = !res_valid || res_ready;
  assign rsp_ready = !empty && can_out;
  assign fire      = rsp_valid && rsp_ready;

  assign load_res        = gecko_get_load_result(rsp_data, head.offset, head.op);
  assign res_speculative = 1'b0;
  assign unused_rs_hi    = ^head.reg_status;

`ifdef GECKO_LOAD_MISALIGN_CHECK_EN
  assign load_value = load_res.misaligned ? '0 : load_res.value;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             misaligned <= 1'b0;
    else if (fire && load_res.misaligned) misaligned <= 1'b1;
  end
`else
  logic unused_misaligned;
  assign load_value        = load_res.value;
  assign unused_misaligned = load_res.misaligned;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid      <= 1'b0;
      res_value      <= '0;
      res_addr       <= '0;
      res_reg_status <= '0;
      res_jump_flag  <= 1'b0;
    end else if (fire) begin
      res_valid      <= 1'b1;
      res_value      <= load_value;
      res_addr       <= head.addr;
      res_reg_status <= head.reg_status[REG_STATUS_WIDTH-1:0];
      res_jump_flag  <= head.jump_flag;
    end else if (res_ready) begin
      res_valid      <= 1'b0;
      res_value      <= '0;
      res_addr       <= '0;
      res_reg_status <= '0;
      res_jump_flag  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gecko_load_writeback.sv
// Self-checking bench: vector table, directed corner sequences and a randomized queue-based reference model.
`timescale 1ns/1ps
module tb_gecko_load_writeback;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned RSW   = 3;
  localparam int unsigned CNTW  = $clog2(DEPTH+1);

  typedef struct {
    logic [4:0]     addr;
    logic [2:0]     op;
    logic [1:0]     off;
    logic [RSW-1:0] rs;
    logic           jf;
  } tb_cmd_t;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  off;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [4:0]      cmd_addr = '0;
  logic [2:0]      cmd_op = '0;
  logic [1:0]      cmd_offset = '0;
  logic [RSW-1:0]  cmd_reg_status = '0;
  logic            cmd_jump_flag = 1'b0;
  logic            rsp_valid = 1'b0;
  logic            rsp_ready;
  logic [31:0]     rsp_data = '0;
  logic            res_valid;
  logic            res_ready = 1'b1;
  logic [31:0]     res_value;
  logic [4:0]      res_addr;
  logic [RSW-1:0]  res_reg_status;
  logic            res_jump_flag;
  logic            res_speculative;
  logic [CNTW-1:0] pending;
`ifdef GECKO_LOAD_MISALIGN_CHECK_EN
  logic            misaligned;
`endif

  gecko_load_writeback #(
    .CMD_DEPTH        (DEPTH),
    .REG_STATUS_WIDTH (RSW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_addr        (cmd_addr),
    .cmd_op          (cmd_op),
    .cmd_offset      (cmd_offset),
    .cmd_reg_status  (cmd_reg_status),
    .cmd_jump_flag   (cmd_jump_flag),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_value       (res_value),
    .res_addr        (res_addr),
    .res_reg_status  (res_reg_status),
    .res_jump_flag   (res_jump_flag),
    .res_speculative (res_speculative),
`ifdef GECKO_LOAD_MISALIGN_CHECK_EN
    .misaligned      (misaligned),
`endif
    .pending         (pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  tb_cmd_t        m_q[$];
  logic           m_valid = 1'b0;
  logic [31:0]    m_value = '0;
  logic [4:0]     m_addr = '0;
  logic [RSW-1:0] m_rs = '0;
  logic           m_jf = 1'b0;
  logic           m_mis = 1'b0;
  logic           s_cmd_ready;
  logic           s_rsp_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] off,
                                           input logic [31:0] data);
    int unsigned b;
    int unsigned h;
    int          sv;
    b = (data >> (8 * off)) & 32'hFF;
    h = (data >> (16 * (off / 2))) & 32'hFFFF;
    case (op)
      3'd0: begin sv = (b > 127) ? int'(b) - 256 : int'(b); return 32'(sv); end
      3'd4: return b;
      3'd1: begin sv = (h > 32767) ? int'(h) - 65536 : int'(h); return 32'(sv); end
      3'd5: return h;
      3'd2: return data;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_mis(input logic [2:0] op, input logic [1:0] off);
    return ((op == 3'd1 || op == 3'd5) && (off % 2 == 1)) || (op == 3'd2 && off != 0);
  endfunction

  function automatic tb_cmd_t mk(input logic [2:0] op, input logic [1:0] off, input logic [4:0] addr);
    tb_cmd_t r;
    r.addr = addr;
    r.op   = op;
    r.off  = off;
    r.rs   = RSW'($urandom);
    r.jf   = 1'($urandom);
    return r;
  endfunction

  // One clock of stimulus: drive, check handshake outputs, advance model, check registered outputs.
  task automatic cycle(input logic cv, input tb_cmd_t c, input logic rv, input logic [31:0] d,
                       input logic rr);
    logic    m_cr;
    logic    m_rr;
    logic    do_fire;
    logic    do_push;
    tb_cmd_t h;
    cmd_valid      = cv;
    cmd_addr       = c.addr;
    cmd_op         = c.op;
    cmd_offset     = c.off;
    cmd_reg_status = c.rs;
    cmd_jump_flag  = c.jf;
    rsp_valid      = rv;
    rsp_data       = d;
    res_ready      = rr;
    #1;
    m_cr = (m_q.size() != DEPTH);
    m_rr = (m_q.size() != 0) && (!m_valid || rr);
    s_cmd_ready = cmd_ready;
    s_rsp_ready = rsp_ready;
    chk("cmd_ready", 32'(cmd_ready), 32'(m_cr));
    chk("rsp_ready", 32'(rsp_ready), 32'(m_rr));
    chk("pending", 32'(pending), 32'(m_q.size()));
    do_fire = rv && m_rr;
    do_push = cv && m_cr;
    if (do_fire) begin
      h       = m_q.pop_front();
      m_valid = 1'b1;
      m_value = ref_load(h.op, h.off, d);
      m_addr  = h.addr;
      m_rs    = h.rs;
      m_jf    = h.jf;
`ifdef GECKO_LOAD_MISALIGN_CHECK_EN
      if (ref_mis(h.op, h.off)) begin
        m_mis   = 1'b1;
        m_value = 32'd0;
      end
`endif
    end else if (rr) begin
      m_valid = 1'b0;
    end
    if (do_push) m_q.push_back(c);
    @(posedge clk);
    #1;
    chk("res_valid", 32'(res_valid), 32'(m_valid));
    chk("res_speculative", 32'(res_speculative), 32'd0);
    if (m_valid) begin
      chk("res_value", res_value, m_value);
      chk("res_addr", 32'(res_addr), 32'(m_addr));
      chk("res_reg_status", 32'(res_reg_status), 32'(m_rs));
      chk("res_jump_flag", 32'(res_jump_flag), 32'(m_jf));
    end
`ifdef GECKO_LOAD_MISALIGN_CHECK_EN
    chk("misaligned", 32'(misaligned), 32'(m_mis));
`endif
  endtask

  task automatic idle(input logic rr);
    cycle(1'b0, mk(3'd0, 2'd0, 5'd0), 1'b0, 32'd0, rr);
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    rsp_valid = 1'b0;
    res_ready = 1'b1;
    rst       = 1'b0;
    #1;
    chk("reset_res_valid", 32'(res_valid), 32'd0);
    chk("reset_pending", 32'(pending), 32'd0);
    chk("reset_rsp_ready", 32'(rsp_ready), 32'd0);
    chk("reset_res_value", res_value, 32'd0);
`ifdef GECKO_LOAD_MISALIGN_CHECK_EN
    chk("reset_misaligned", 32'(misaligned), 32'd0);
`endif
    m_q.delete();
    m_valid = 1'b0;
    m_mis   = 1'b0;
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[14];
    vecs[0]  = '{3'd0, 2'd0, 5'd1,  32'h1234_56F0, 32'hFFFF_FFF0};
    vecs[1]  = '{3'd0, 2'd1, 5'd2,  32'h1234_56F0, 32'h0000_0056};
    vecs[2]  = '{3'd4, 2'd3, 5'd3,  32'h80FF_1234, 32'h0000_0080};
    vecs[3]  = '{3'd4, 2'd2, 5'd4,  32'h80FF_1234, 32'h0000_00FF};
    vecs[4]  = '{3'd1, 2'd2, 5'd5,  32'h8001_7FFF, 32'hFFFF_8001};
    vecs[5]  = '{3'd1, 2'd0, 5'd6,  32'h8001_7FFF, 32'h0000_7FFF};
    vecs[6]  = '{3'd5, 2'd2, 5'd7,  32'h8001_7FFF, 32'h0000_8001};
    vecs[7]  = '{3'd5, 2'd0, 5'd8,  32'h0000_FFFF, 32'h0000_FFFF};
    vecs[8]  = '{3'd2, 2'd0, 5'd9,  32'hCAFE_BABE, 32'hCAFE_BABE};
    vecs[9]  = '{3'd3, 2'd0, 5'd10, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[10] = '{3'd6, 2'd0, 5'd11, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[11] = '{3'd7, 2'd0, 5'd12, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[12] = '{3'd0, 2'd2, 5'd13, 32'h007F_0000, 32'h0000_007F};
    vecs[13] = '{3'd2, 2'd0, 5'd0,  32'h0BAD_F00D, 32'h0BAD_F00D};

    do_reset();

    // Single LB at offset 3, result exactly one cycle after the response fires
    cycle(1'b1, mk(3'd0, 2'd3, 5'd5), 1'b0, 32'd0, 1'b1);
    chk("seq1_no_early_valid", 32'(res_valid), 32'd0);
    cycle(1'b0, mk(3'd0, 2'd0, 5'd0), 1'b1, 32'h80FF_1234, 1'b1);
    chk("seq1_rsp_ready", 32'(s_rsp_ready), 32'd1);
    chk("seq1_valid", 32'(res_valid), 32'd1);
    chk("seq1_value", res_value, 32'hFFFF_FF80);
    chk("seq1_addr", 32'(res_addr), 32'd5);
    idle(1'b1);
    chk("seq1_drop", 32'(res_valid), 32'd0);

    for (int i = 0; i < 14; i++) begin
      cycle(1'b1, mk(vecs[i].op, vecs[i].off, vecs[i].addr), 1'b0, 32'd0, 1'b1);
      cycle(1'b0, mk(3'd0, 2'd0, 5'd0), 1'b1, vecs[i].data, 1'b1);
      chk($sformatf("vec%0d_valid", i), 32'(res_valid), 32'd1);
      chk($sformatf("vec%0d_value", i), res_value, vecs[i].exp);
      chk($sformatf("vec%0d_addr", i), 32'(res_addr), 32'(vecs[i].addr));
    end
    idle(1'b1);

    // Back-to-back results on consecutive cycles
    cycle(1'b1, mk(3'd5, 2'd2, 5'd1), 1'b0, 32'd0, 1'b1);
    cycle(1'b1, mk(3'd1, 2'd0, 5'd2), 1'b0, 32'd0, 1'b1);
    cycle(1'b1, mk(3'd2, 2'd0, 5'd3), 1'b0, 32'd0, 1'b1);
    cycle(1'b0, mk(3'd0, 2'd0, 5'd0), 1'b1, 32'hBEEF_0001, 1'b1);
    chk("b2b_0", res_value, 32'h0000_BEEF);
    cycle(1'b0, mk(3'd0, 2'd0, 5'd0), 1'b1, 32'h0000_8001, 1'b1);
    chk("b2b_1", res_value, 32'hFFFF_8001);
    cycle(1'b0, mk(3'd0, 2'd0, 5'd0), 1'b1, 32'hDEAD_BEEF, 1'b1);
    chk("b2b_2", res_value, 32'hDEAD_BEEF);
    chk("b2b_valid", 32'(res_valid), 32'd1);
    idle(1'b1);

    // Fill the queue, hold a fifth command, then free one slot and wrap pointers
    for (int i = 0; i < 4; i++) cycle(1'b1, mk(3'd2, 2'd0, 5'(i + 20)), 1'b0, 32'd0, 1'b1);
    chk("full_pending", 32'(pending), 32'd4);
    chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    cycle(1'b1, mk(3'd4, 2'd1, 5'd24), 1'b0, 32'd0, 1'b1);
    chk("full_held_ready", 32'(s_cmd_ready), 32'd0);
    chk("full_held_pending", 32'(pending), 32'd4);
    cycle(1'b1, mk(3'd4, 2'd1, 5'd24), 1'b1, 32'h0102_0304, 1'b1);
    chk("full_pop_rsp_ready", 32'(s_rsp_ready), 32'd1);
    chk("full_pop_value", res_value, 32'h0102_0304);
    chk("full_pop_pending", 32'(pending), 32'd3);
    chk("full_pop_cmd_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 10; i++)
      cycle(1'b1, mk(3'($urandom), 2'($urandom), 5'($urandom)), 1'b1, $urandom, 1'b1);
    for (int i = 0; i < 2 * DEPTH && m_q.size() != 0; i++)
      cycle(1'b0, mk(3'd0, 2'd0, 5'd0), 1'b1, $urandom, 1'b1);
    chk("wrap_drained", 32'(pending), 32'd0);
    idle(1'b1);

    // Output stall holds the result and blocks the next response
    cycle(1'b1, mk(3'd1, 2'd0, 5'd9), 1'b0, 32'd0, 1'b1);
    cycle(1'b1, mk(3'd4, 2'd1, 5'd10), 1'b0, 32'd0, 1'b1);
    cycle(1'b0, mk(3'd0, 2'd0, 5'd0), 1'b1, 32'h0000_9ABC, 1'b0);
    chk("stall_first", res_value, 32'hFFFF_9ABC);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, mk(3'd0, 2'd0, 5'd0), 1'b1, 32'h0000_5600, 1'b0);
      chk("stall_rsp_ready", 32'(s_rsp_ready), 32'd0);
      chk("stall_hold_value", res_value, 32'hFFFF_9ABC);
      chk("stall_hold_valid", 32'(res_valid), 32'd1);
    end
    cycle(1'b0, mk(3'd0, 2'd0, 5'd0), 1'b1, 32'h0000_5600, 1'b1);
    chk("stall_release_ready", 32'(s_rsp_ready), 32'd1);
    chk("stall_second", res_value, 32'h0000_0056);
    idle(1'b1);

    // No bypass: response alongside a push into an empty queue waits one cycle
    cycle(1'b1, mk(3'd2, 2'd0, 5'd7), 1'b1, 32'h1111_2222, 1'b1);
    chk("nobypass_ready", 32'(s_rsp_ready), 32'd0);
    chk("nobypass_valid", 32'(res_valid), 32'd0);
    cycle(1'b0, mk(3'd0, 2'd0, 5'd0), 1'b1, 32'h1111_2222, 1'b1);
    chk("nobypass_fire", 32'(s_rsp_ready), 32'd1);
    chk("nobypass_value", res_value, 32'h1111_2222);
    cycle(1'b1, mk(3'd2, 2'd0, 5'd8), 1'b0, 32'd0, 1'b1);
    cycle(1'b1, mk(3'd2, 2'd0, 5'd9), 1'b0, 32'd0, 1'b1);
    cycle(1'b0, mk(3'd0, 2'd0, 5'd0), 1'b1, 32'h3333_4444, 1'b0);
    chk("midrst_pre_valid", 32'(res_valid), 32'd1);
    chk("midrst_pre_pending", 32'(pending), 32'd1);
    do_reset();

`ifdef GECKO_LOAD_MISALIGN_CHECK_EN
    cycle(1'b1, mk(3'd2, 2'd1, 5'd3), 1'b0, 32'd0, 1'b1);
    cycle(1'b0, mk(3'd0, 2'd0, 5'd0), 1'b1, 32'hDEAD_BEEF, 1'b1);
    chk("mis_value", res_value, 32'd0);
    chk("mis_flag", 32'(misaligned), 32'd1);
    cycle(1'b1, mk(3'd2, 2'd0, 5'd4), 1'b0, 32'd0, 1'b1);
    cycle(1'b0, mk(3'd0, 2'd0, 5'd0), 1'b1, 32'h1234_5678, 1'b1);
    chk("mis_aligned_value", res_value, 32'h1234_5678);
    chk("mis_sticky", 32'(misaligned), 32'd1);
    idle(1'b1);
    do_reset();
`endif

    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 99) < 60),
            mk(3'($urandom), 2'($urandom), 5'($urandom)),
            1'($urandom_range(0, 99) < 60),
            $urandom,
            1'($urandom_range(0, 99) < 75));
    end
    for (int i = 0; i < 2 * DEPTH + 2 && (m_q.size() != 0 || m_valid); i++)
      cycle(1'b0, mk(3'd0, 2'd0, 5'd0), 1'b1, $urandom, 1'b1);
    chk("final_pending", 32'(pending), 32'd0);
    chk("final_valid", 32'(res_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
